// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared opcode, request-kind and state definitions for alu_op_sequencer
package alu_op_sequencer_pkg;

    typedef enum logic [4:0] {
        ALU_LSH = 5'b00000,
        ALU_RSH = 5'b00001,
        ALU_AND = 5'b00010,
        ALU_OR  = 5'b00011,
        ALU_GEQ = 5'b01000,
        ALU_EQ  = 5'b01001,
        ALU_NEG = 5'b01010,
        ALU_ADD = 5'b01011,
        ALU_NEQ = 5'b01101
    } alu_op_e;

    localparam logic KIND_PASS = 1'b0;
    localparam logic KIND_MUL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC    = 3'd1,
        ST_MUL_ADD = 3'd2,
        ST_MUL_LSH = 3'd3,
        ST_MUL_RSH = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - drives the combinational ALU for single ops and shift-add multiplies
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int MUL_ITERS = 8,
    parameter int DW        = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_kind,
    input  logic [4:0]    req_op,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    input  logic          req_sc,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_zero,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [4:0]    alu_op,
    output logic          alu_sc,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_zero
);

    localparam int CW = $clog2(MUL_ITERS + 1);

    seq_state_e    state, state_nxt;
    logic [DW-1:0] acc, acc_nxt;
    logic [DW-1:0] a_sh, a_sh_nxt;
    logic [DW-1:0] b_sh, b_sh_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] rsp_data_nxt;
    logic          rsp_zero_nxt;
    logic [DW-1:0] alu_a_nxt, alu_b_nxt;
    logic [4:0]    alu_op_nxt;
    logic          alu_sc_nxt;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_DONE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            acc      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= ALU_ADD;
            alu_sc   <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            a_sh     <= a_sh_nxt;
            b_sh     <= b_sh_nxt;
            cnt      <= cnt_nxt;
            rsp_data <= rsp_data_nxt;
            rsp_zero <= rsp_zero_nxt;
            alu_a    <= alu_a_nxt;
            alu_b    <= alu_b_nxt;
            alu_op   <= alu_op_nxt;
            alu_sc   <= alu_sc_nxt;
        end
    end

    // ALU pins are registered: each transition loads the operands the next state presents,
    // so IDLE and DONE simply keep whatever was last driven.
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        a_sh_nxt     = a_sh;
        b_sh_nxt     = b_sh;
        cnt_nxt      = cnt;
        rsp_data_nxt = rsp_data;
        rsp_zero_nxt = rsp_zero;
        alu_a_nxt    = alu_a;
        alu_b_nxt    = alu_b;
        alu_op_nxt   = alu_op;
        alu_sc_nxt   = alu_sc;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_kind == KIND_MUL) begin
                        state_nxt  = ST_MUL_ADD;
                        acc_nxt    = '0;
                        a_sh_nxt   = req_a;
                        b_sh_nxt   = req_b;
                        cnt_nxt    = '0;
                        alu_a_nxt  = '0;
                        alu_b_nxt  = req_a;
                        alu_op_nxt = ALU_ADD;
                        alu_sc_nxt = 1'b0;
                    end else begin
                        state_nxt  = ST_EXEC;
                        alu_a_nxt  = req_a;
                        alu_b_nxt  = req_b;
                        alu_op_nxt = req_op;
                        alu_sc_nxt = req_sc;
                    end
                end
            end
            ST_EXEC: begin
                rsp_data_nxt = alu_out;
                rsp_zero_nxt = alu_zero;
                state_nxt    = ST_DONE;
            end
            ST_MUL_ADD: begin
                if (b_sh[0]) acc_nxt = alu_out;
                state_nxt  = ST_MUL_LSH;
                alu_a_nxt  = a_sh;
                alu_b_nxt  = '0;
                alu_op_nxt = ALU_LSH;
                alu_sc_nxt = 1'b0;
            end
            ST_MUL_LSH: begin
                a_sh_nxt   = alu_out;
                state_nxt  = ST_MUL_RSH;
                alu_a_nxt  = b_sh;
                alu_b_nxt  = '0;
                alu_op_nxt = ALU_RSH;
                alu_sc_nxt = 1'b0;
            end
            ST_MUL_RSH: begin
                b_sh_nxt = alu_out;
                if (cnt == CW'(MUL_ITERS - 1)) begin
                    state_nxt    = ST_DONE;
                    rsp_data_nxt = acc;
                    rsp_zero_nxt = (acc == '0);
                end else begin
                    cnt_nxt    = cnt + CW'(1);
                    state_nxt  = ST_MUL_ADD;
                    alu_a_nxt  = acc;
                    alu_b_nxt  = a_sh;
                    alu_op_nxt = ALU_ADD;
                    alu_sc_nxt = 1'b0;
                end
            end
            ST_DONE: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer against a behavioural ALU
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       req_valid, req_ready, req_kind, req_sc;
    logic [4:0] req_op;
    logic [7:0] req_a, req_b;
    logic       rsp_valid, rsp_ready, rsp_zero;
    logic [7:0] rsp_data;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [4:0] alu_op;
    logic       alu_sc, alu_zero;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    alu_op_sequencer #(.MUL_ITERS(8), .DW(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_sc(req_sc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sc(alu_sc),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    function automatic logic [7:0] alu_f(input logic [4:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic sc);
        case (op)
            5'b00000: return {a[6:0], sc};
            5'b00001: return {1'b0, a[7:1]};
            5'b00010: return a & b;
            5'b00011: return a | b;
            5'b01000: return (a >= b) ? 8'd1 : 8'd0;
            5'b01001: return (a == b) ? 8'd1 : 8'd0;
            5'b01010: return 8'(0 - int'(a));
            5'b01011: return 8'(int'(a) + int'(b));
            5'b01101: return (a != b) ? 8'd1 : 8'd0;
            default:  return 8'd0;
        endcase
    endfunction

    always_comb begin
        alu_out  = alu_f(alu_op, alu_a, alu_b, alu_sc);
        alu_zero = (alu_out == 8'd0);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, " req_ready"}, int'(req_ready), 1);
        chk({name, " rsp_valid"}, int'(rsp_valid), 0);
        chk({name, " rsp_data"},  int'(rsp_data),  0);
        chk({name, " rsp_zero"},  int'(rsp_zero),  0);
        chk({name, " alu_pins"},  int'({alu_a, alu_b, alu_sc}), 0);
        chk({name, " alu_op"},    int'(alu_op), 32'h0B);
    endtask

    task automatic run_req(input string name, input logic kind, input logic [4:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic sc,
                           input logic [7:0] exp_d, input logic exp_z, input bit early,
                           input bit chk_seq, input int hold);
        int cyc, guard, seq_bad, exp_lat;
        logic [4:0] exp_op;
        exp_lat = (kind == KIND_MUL) ? 24 : 1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge Clk); #1; guard++;
        end
        chk({name, " req_ready before accept"}, int'(req_ready), 1);
        req_valid = 1'b1; req_kind = kind; req_op = op; req_a = a; req_b = b; req_sc = sc;
        rsp_ready = early;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        cyc = 0; seq_bad = 0;
        while (!rsp_valid && cyc < 100) begin
            if (chk_seq) begin
                exp_op = (cyc % 3 == 0) ? ALU_ADD : (cyc % 3 == 1) ? ALU_LSH : ALU_RSH;
                if (alu_op !== exp_op) seq_bad++;
            end
            @(posedge Clk); #1; cyc++;
        end
        chk({name, " latency"}, cyc, exp_lat);
        chk({name, " rsp_data"}, int'(rsp_data), int'(exp_d));
        chk({name, " rsp_zero"}, int'(rsp_zero), int'(exp_z));
        chk({name, " req_ready in done"}, int'(req_ready), 0);
        if (chk_seq) chk({name, " alu_op sequence errors"}, seq_bad, 0);
        if (hold > 0) begin
            req_valid = 1'b1; req_kind = KIND_PASS; req_op = ALU_ADD; req_a = 8'h11; req_b = 8'h22;
            for (int i = 0; i < hold; i++) begin
                @(posedge Clk); #1;
                chk({name, " hold rsp_valid"}, int'(rsp_valid), 1);
                chk({name, " hold rsp_data"}, int'(rsp_data), int'(exp_d));
                chk({name, " hold req_ready"}, int'(req_ready), 0);
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge Clk); #1;
        chk({name, " rsp_valid after handshake"}, int'(rsp_valid), 0);
        chk({name, " req_ready after handshake"}, int'(req_ready), 1);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic       kind;
        logic [4:0] op;
        logic [7:0] a, b;
        logic       sc;
        logic [7:0] exp_d;
        logic       exp_z;
        bit         early;
    } vec_t;

    vec_t vecs[12];
    logic [4:0] ops[10] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0D, 5'h1F};

    initial begin
        int hi_cnt;
        logic k, s, z;
        logic [4:0] o;
        logic [7:0] ra, rb, d;

        vecs[0]  = '{"pass_add",   KIND_PASS, ALU_ADD, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b1};
        vecs[1]  = '{"pass_eq",    KIND_PASS, ALU_EQ,  8'h02, 8'h02, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[2]  = '{"pass_neg",   KIND_PASS, ALU_NEG, 8'h01, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[3]  = '{"pass_lsh",   KIND_PASS, ALU_LSH, 8'h81, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[4]  = '{"pass_rsh",   KIND_PASS, ALU_RSH, 8'h81, 8'h00, 1'b0, 8'h40, 1'b0, 1'b1};
        vecs[5]  = '{"pass_and0",  KIND_PASS, ALU_AND, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{"pass_geq",   KIND_PASS, ALU_GEQ, 8'h10, 8'h10, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{"pass_undef", KIND_PASS, 5'h1F,   8'h12, 8'h34, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{"mul_13x11",  KIND_MUL,  5'h00,   8'd13, 8'd11, 1'b1, 8'h8F, 1'b0, 1'b0};
        vecs[9]  = '{"mul_wrap",   KIND_MUL,  5'h00,   8'h10, 8'h10, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[10] = '{"mul_by0",    KIND_MUL,  5'h00,   8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{"mul_ff_ff",  KIND_MUL,  5'h00,   8'hFF, 8'hFF, 1'b0, 8'h01, 1'b0, 1'b0};

        Reset = 1'b1; req_valid = 1'b0; req_kind = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        req_sc = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1 chk_reset_vals("reset");
        @(negedge Clk); Reset = 1'b0;
        @(posedge Clk); #1;

        foreach (vecs[i])
            run_req(vecs[i].name, vecs[i].kind, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sc,
                    vecs[i].exp_d, vecs[i].exp_z, vecs[i].early, vecs[i].kind == KIND_MUL, 0);

        // backpressure on a completed multiply, with a competing request held on req_valid
        run_req("mul_backpressure", KIND_MUL, 5'h00, 8'd7, 8'd9, 1'b0, 8'd63, 1'b0, 1'b0, 1'b0, 5);
        run_req("pass_after_bp", KIND_PASS, ALU_OR, 8'h50, 8'h05, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 0);

        // reset ten cycles into a multiply
        req_valid = 1'b1; req_kind = KIND_MUL; req_a = 8'd13; req_b = 8'd11;
        @(posedge Clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (9) @(posedge Clk);
        #1 Reset = 1'b1;
        #1 chk_reset_vals("mid_mul_reset");
        @(negedge Clk); Reset = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge Clk); #1;
            if (rsp_valid) hi_cnt++;
        end
        chk("mid_mul_reset no response", hi_cnt, 0);
        rsp_ready = 1'b0;
        run_req("pass_after_reset", KIND_PASS, ALU_ADD, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 0);

        // random requests against the reference: single ALU op or product mod 256
        for (int n = 0; n < 20; n++) begin
            k  = 1'($urandom_range(0, 1));
            o  = ops[$urandom_range(0, 9)];
            ra = 8'($urandom);
            rb = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            s  = 1'($urandom_range(0, 1));
            if (k == KIND_MUL) d = 8'((int'(ra) * int'(rb)) % 256);
            else               d = alu_f(o, ra, rb, s);
            z = (d == 8'd0);
            run_req($sformatf("rand%0d", n), k, o, ra, rb, s, d, z, 1'($urandom_range(0, 1)), k, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
